// File: rtl/vga_pkg.sv
// Shared mode constants and types for the VGA raster timing path.
// Holds the 640x480@60 defaults, a tiny simulation mode and the region encoding.
package vga_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel tick
  localparam int unsigned VgaHActive = 640;
  localparam int unsigned VgaHFp     = 16;
  localparam int unsigned VgaHSync   = 96;
  localparam int unsigned VgaHBp     = 48;
  localparam int unsigned VgaVActive = 480;
  localparam int unsigned VgaVFp     = 10;
  localparam int unsigned VgaVSync   = 2;
  localparam int unsigned VgaVBp     = 33;

  // Tiny mode: a whole frame is 14 x 7 ticks
  localparam int unsigned SimHActive = 8;
  localparam int unsigned SimHFp     = 2;
  localparam int unsigned SimHSync   = 3;
  localparam int unsigned SimHBp     = 1;
  localparam int unsigned SimVActive = 4;
  localparam int unsigned SimVFp     = 1;
  localparam int unsigned SimVSync   = 1;
  localparam int unsigned SimVBp     = 1;

  // Scan order on each axis
  typedef enum logic [1:0] {
    RegionActive,
    RegionFp,
    RegionSync,
    RegionBp
  } region_e;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic bit axis_ok(input int unsigned active, input int unsigned fp,
                                 input int unsigned sync, input int unsigned bp);
    return (active != 0) && (fp != 0) && (sync != 0) && (bp != 0);
  endfunction

endpackage

// File: rtl/vga_scan_counter.sv
// Horizontal/vertical raster counter pair with tick enable.
// The reset position is a parameter so the same block serves as a look-ahead scanner.
module vga_scan_counter #(
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_TOTAL = 525,
  parameter int unsigned H_INIT  = 0,
  parameter int unsigned V_INIT  = 0,
  localparam int unsigned X_W    = $clog2(H_TOTAL),
  localparam int unsigned Y_W    = $clog2(V_TOTAL)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_i,
  output logic [X_W-1:0] h_o,
  output logic [Y_W-1:0] v_o
);

  localparam logic [X_W-1:0] HLast = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] VLast = Y_W'(V_TOTAL - 1);
  localparam logic [X_W-1:0] HInit = X_W'(H_INIT);
  localparam logic [Y_W-1:0] VInit = Y_W'(V_INIT);

  logic [X_W-1:0] h_d, h_q;
  logic [Y_W-1:0] v_d, v_q;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (en_i) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + Y_W'(1);
      end else begin
        h_d = h_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_q <= HInit;
      v_q <= VInit;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o = h_q;
  assign v_o = v_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, data enable, coordinates, strobes and a
// look-ahead coordinate port for fixed-latency renderers. All outputs are registered.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VgaHActive,
  parameter int unsigned H_FP     = VgaHFp,
  parameter int unsigned H_SYNC   = VgaHSync,
  parameter int unsigned H_BP     = VgaHBp,
  parameter int unsigned V_ACTIVE = VgaVActive,
  parameter int unsigned V_FP     = VgaVFp,
  parameter int unsigned V_SYNC   = VgaVSync,
  parameter int unsigned V_BP     = VgaVBp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned LEAD     = 2,
  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned X_W     = $clog2(H_TOTAL),
  localparam int unsigned Y_W     = $clog2(V_TOTAL)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           pix_en_i,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic           de_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           line_start_o,
  output logic           frame_start_o,
  output logic [X_W-1:0] fetch_x_o,
  output logic [Y_W-1:0] fetch_y_o,
  output logic           fetch_de_o
);

  if (!axis_ok(H_ACTIVE, H_FP, H_SYNC, H_BP) || !axis_ok(V_ACTIVE, V_FP, V_SYNC, V_BP))
  begin : g_bad_region
    $error("vga_timing_gen: every timing region must be at least one tick wide");
  end

  if (LEAD == 0 || LEAD >= H_TOTAL) begin : g_bad_lead
    $error("vga_timing_gen: LEAD must lie in 1..H_TOTAL-1");
  end

  localparam logic [X_W-1:0] HFpStart   = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HSyncStart = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HBpStart   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] VFpStart   = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VSyncStart = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VBpStart   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [X_W-1:0] LeadX      = X_W'(LEAD);

  function automatic region_e h_region(input logic [X_W-1:0] h);
    region_e r;
    if (h < HFpStart) begin
      r = RegionActive;
    end else if (h < HSyncStart) begin
      r = RegionFp;
    end else if (h < HBpStart) begin
      r = RegionSync;
    end else begin
      r = RegionBp;
    end
    return r;
  endfunction

  function automatic region_e v_region(input logic [Y_W-1:0] v);
    region_e r;
    if (v < VFpStart) begin
      r = RegionActive;
    end else if (v < VSyncStart) begin
      r = RegionFp;
    end else if (v < VBpStart) begin
      r = RegionSync;
    end else begin
      r = RegionBp;
    end
    return r;
  endfunction

  logic [X_W-1:0] h_cnt, fh_cnt;
  logic [Y_W-1:0] v_cnt, fv_cnt;

  vga_scan_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_INIT  (0),
    .V_INIT  (0)
  ) u_main_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (pix_en_i),
    .h_o    (h_cnt),
    .v_o    (v_cnt)
  );

  // Free-running twin started LEAD ticks ahead; it wraps independently so the offset
  // holds across line and frame boundaries without any modular arithmetic.
  vga_scan_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_INIT  (LEAD),
    .V_INIT  (0)
  ) u_fetch_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (pix_en_i),
    .h_o    (fh_cnt),
    .v_o    (fv_cnt)
  );

  region_e h_reg, v_reg, fh_reg, fv_reg;

  assign h_reg  = h_region(h_cnt);
  assign v_reg  = v_region(v_cnt);
  assign fh_reg = h_region(fh_cnt);
  assign fv_reg = v_region(fv_cnt);

  logic           hsync_d, hsync_q;
  logic           vsync_d, vsync_q;
  logic           de_d, de_q;
  logic [X_W-1:0] x_d, x_q;
  logic [Y_W-1:0] y_d, y_q;
  logic           line_start_d, line_start_q;
  logic           frame_start_d, frame_start_q;
  logic [X_W-1:0] fetch_x_d, fetch_x_q;
  logic [Y_W-1:0] fetch_y_d, fetch_y_q;
  logic           fetch_de_d, fetch_de_q;

  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    fetch_x_d     = fetch_x_q;
    fetch_y_d     = fetch_y_q;
    fetch_de_d    = fetch_de_q;
    // Strobes drop on idle edges so each lasts exactly one clk_i cycle
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en_i) begin
      hsync_d       = (h_reg == RegionSync) ? HS_POL : ~HS_POL;
      vsync_d       = (v_reg == RegionSync) ? VS_POL : ~VS_POL;
      de_d          = (h_reg == RegionActive) && (v_reg == RegionActive);
      x_d           = h_cnt;
      y_d           = v_cnt;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      fetch_x_d     = fh_cnt;
      fetch_y_d     = fv_cnt;
      fetch_de_d    = (fh_reg == RegionActive) && (fv_reg == RegionActive);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      fetch_x_q     <= LeadX;
      fetch_y_q     <= '0;
      fetch_de_q    <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      fetch_x_q     <= fetch_x_d;
      fetch_y_q     <= fetch_y_d;
      fetch_de_q    <= fetch_de_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign fetch_x_o     = fetch_x_q;
  assign fetch_y_o     = fetch_y_q;
  assign fetch_de_o    = fetch_de_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small LEAD=3, small inverted sync LEAD=1,
// default 640x480) share one stimulus stream and are scored against an arithmetic model.
module tb_vga_timing_gen;

  localparam int unsigned SXW = $clog2(14);
  localparam int unsigned SYW = $clog2(7);
  localparam int unsigned DXW = $clog2(800);
  localparam int unsigned DYW = $clog2(525);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic           hs_a, vs_a, de_a, ls_a, fs_a, fde_a;
  logic [SXW-1:0] x_a, fx_a;
  logic [SYW-1:0] y_a, fy_a;
  logic           hs_b, vs_b, de_b, ls_b, fs_b, fde_b;
  logic [SXW-1:0] x_b, fx_b;
  logic [SYW-1:0] y_b, fy_b;
  logic           hs_c, vs_c, de_c, ls_c, fs_c, fde_c;
  logic [DXW-1:0] x_c, fx_c;
  logic [DYW-1:0] y_c, fy_c;

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1'b0), .VS_POL (1'b0), .LEAD (3)
  ) u_dut_a (
    .clk_i (clk), .rst_ni (rst_n), .pix_en_i (pix_en),
    .hsync_o (hs_a), .vsync_o (vs_a), .de_o (de_a), .x_o (x_a), .y_o (y_a),
    .line_start_o (ls_a), .frame_start_o (fs_a),
    .fetch_x_o (fx_a), .fetch_y_o (fy_a), .fetch_de_o (fde_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1'b1), .VS_POL (1'b1), .LEAD (1)
  ) u_dut_b (
    .clk_i (clk), .rst_ni (rst_n), .pix_en_i (pix_en),
    .hsync_o (hs_b), .vsync_o (vs_b), .de_o (de_b), .x_o (x_b), .y_o (y_b),
    .line_start_o (ls_b), .frame_start_o (fs_b),
    .fetch_x_o (fx_b), .fetch_y_o (fy_b), .fetch_de_o (fde_b)
  );

  vga_timing_gen u_dut_c (
    .clk_i (clk), .rst_ni (rst_n), .pix_en_i (pix_en),
    .hsync_o (hs_c), .vsync_o (vs_c), .de_o (de_c), .x_o (x_c), .y_o (y_c),
    .line_start_o (ls_c), .frame_start_o (fs_c),
    .fetch_x_o (fx_c), .fetch_y_o (fy_c), .fetch_de_o (fde_c)
  );

  typedef struct packed {
    logic        hs, vs, de, ls, fs, fde;
    logic [15:0] x, y, fx, fy;
  } out_t;

  typedef struct packed {
    out_t a, b, c;
  } exp_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, lead;
    bit hpol, vpol;
  } mode_t;

  typedef struct {
    bit rst_n, en;
    int x, y;
    bit de, ls, fs;
    int fx;
    bit hs_b, vs_b;
  } vec_t;

  exp_t  sb_q[$];
  mode_t ma, mb, mc;
  out_t  last_a, last_b, last_c;
  int    t;
  int    n_checks = 0;
  int    n_fail = 0;

  function automatic out_t model_tick(input mode_t m, input int tick);
    out_t o;
    int ht, vt, ft, ft2, x, y, fx, fy;
    ht = m.ha + m.hf + m.hs + m.hb;
    vt = m.va + m.vf + m.vs + m.vb;
    ft = tick % (ht * vt);
    ft2 = (tick + m.lead) % (ht * vt);
    x = ft % ht;
    y = ft / ht;
    fx = ft2 % ht;
    fy = ft2 / ht;
    o.hs = (x >= m.ha + m.hf && x < m.ha + m.hf + m.hs) ? m.hpol : !m.hpol;
    o.vs = (y >= m.va + m.vf && y < m.va + m.vf + m.vs) ? m.vpol : !m.vpol;
    o.de = (x < m.ha) && (y < m.va);
    o.fde = (fx < m.ha) && (fy < m.va);
    o.ls = (x == 0);
    o.fs = (ft == 0);
    o.x = 16'(x);
    o.y = 16'(y);
    o.fx = 16'(fx);
    o.fy = 16'(fy);
    return o;
  endfunction

  function automatic out_t model_reset(input mode_t m);
    out_t o;
    o = '0;
    o.hs = !m.hpol;
    o.vs = !m.vpol;
    o.fx = 16'(m.lead);
    return o;
  endfunction

  function automatic out_t act_a();
    out_t o;
    o.hs = hs_a; o.vs = vs_a; o.de = de_a; o.ls = ls_a; o.fs = fs_a; o.fde = fde_a;
    o.x = 16'(x_a); o.y = 16'(y_a); o.fx = 16'(fx_a); o.fy = 16'(fy_a);
    return o;
  endfunction

  function automatic out_t act_b();
    out_t o;
    o.hs = hs_b; o.vs = vs_b; o.de = de_b; o.ls = ls_b; o.fs = fs_b; o.fde = fde_b;
    o.x = 16'(x_b); o.y = 16'(y_b); o.fx = 16'(fx_b); o.fy = 16'(fy_b);
    return o;
  endfunction

  function automatic out_t act_c();
    out_t o;
    o.hs = hs_c; o.vs = vs_c; o.de = de_c; o.ls = ls_c; o.fs = fs_c; o.fde = fde_c;
    o.x = 16'(x_c); o.y = 16'(y_c); o.fx = 16'(fx_c); o.fy = 16'(fy_c);
    return o;
  endfunction

  task automatic check_out(input string nm, input out_t act, input out_t req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t: got hs=%0b vs=%0b de=%0b ls=%0b fs=%0b x=%0d y=%0d fx=%0d fy=%0d fde=%0b; required hs=%0b vs=%0b de=%0b ls=%0b fs=%0b x=%0d y=%0d fx=%0d fy=%0d fde=%0b",
               nm, $time, act.hs, act.vs, act.de, act.ls, act.fs, act.x, act.y, act.fx,
               act.fy, act.fde, req.hs, req.vs, req.de, req.ls, req.fs, req.x, req.y,
               req.fx, req.fy, req.fde);
    end
  endtask

  task automatic check_val(input string nm, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Drive one clock of stimulus, queue the model's prediction, score it after the edge.
  task automatic step(input bit r, input bit e);
    exp_t ex, got;
    rst_n = r;
    pix_en = e;
    if (!r) begin
      ex.a = model_reset(ma);
      ex.b = model_reset(mb);
      ex.c = model_reset(mc);
      t = 0;
    end else if (e) begin
      ex.a = model_tick(ma, t);
      ex.b = model_tick(mb, t);
      ex.c = model_tick(mc, t);
      t++;
    end else begin
      ex.a = last_a; ex.a.ls = 1'b0; ex.a.fs = 1'b0;
      ex.b = last_b; ex.b.ls = 1'b0; ex.b.fs = 1'b0;
      ex.c = last_c; ex.c.ls = 1'b0; ex.c.fs = 1'b0;
    end
    last_a = ex.a;
    last_b = ex.b;
    last_c = ex.c;
    sb_q.push_back(ex);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, required one entry");
    end else begin
      got = sb_q.pop_front();
      check_out("dut_a", act_a(), got.a);
      check_out("dut_b", act_b(), got.b);
      check_out("dut_c", act_c(), got.c);
    end
  endtask

  vec_t vecs[8];
  int   c_hs, c_vs, c_de, c_ls, c_fs, c_hsb;

  initial begin
    ma = '{ha: 8, hf: 2, hs: 3, hb: 1, va: 4, vf: 1, vs: 1, vb: 1, lead: 3,
           hpol: 1'b0, vpol: 1'b0};
    mb = '{ha: 8, hf: 2, hs: 3, hb: 1, va: 4, vf: 1, vs: 1, vb: 1, lead: 1,
           hpol: 1'b1, vpol: 1'b1};
    mc = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, lead: 2,
           hpol: 1'b0, vpol: 1'b0};
    t = 0;

    //               rst en  x  y  de ls fs fx hsb vsb
    vecs[0] = '{1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rst_n, vecs[i].en);
      check_val($sformatf("vec%0d.x", i), int'(x_a), vecs[i].x);
      check_val($sformatf("vec%0d.y", i), int'(y_a), vecs[i].y);
      check_val($sformatf("vec%0d.de", i), int'(de_a), int'(vecs[i].de));
      check_val($sformatf("vec%0d.ls", i), int'(ls_a), int'(vecs[i].ls));
      check_val($sformatf("vec%0d.fs", i), int'(fs_a), int'(vecs[i].fs));
      check_val($sformatf("vec%0d.fx", i), int'(fx_a), vecs[i].fx);
      check_val($sformatf("vec%0d.hs_b", i), int'(hs_b), int'(vecs[i].hs_b));
      check_val($sformatf("vec%0d.vs_b", i), int'(vs_b), int'(vecs[i].vs_b));
    end

    // Full-rate small frames: per-frame region counts, plus de edge corners
    step(1'b0, 1'b1);
    c_hs = 0; c_vs = 0; c_de = 0; c_ls = 0; c_fs = 0; c_hsb = 0;
    for (int i = 0; i < 196; i++) begin
      step(1'b1, 1'b1);
      if (i < 98) begin
        c_hs += int'(!hs_a);
        c_vs += int'(!vs_a);
        c_de += int'(de_a);
        c_ls += int'(ls_a);
        c_fs += int'(fs_a);
        c_hsb += int'(hs_b);
      end
      if (x_a == SXW'(7) && y_a < SYW'(4)) check_val("de_last_active_col", int'(de_a), 1);
      if (x_a == SXW'(8)) check_val("de_first_porch_col", int'(de_a), 0);
      if (y_a == SYW'(4)) check_val("de_first_porch_line", int'(de_a), 0);
    end
    check_val("small_hsync_ticks", c_hs, 21);
    check_val("small_vsync_ticks", c_vs, 14);
    check_val("small_de_ticks", c_de, 32);
    check_val("small_line_starts", c_ls, 7);
    check_val("small_frame_starts", c_fs, 1);
    check_val("small_hsync_b_ticks", c_hsb, 21);

    // Half-rate: strobes must still be single clk_i cycles
    step(1'b0, 1'b0);
    c_ls = 0; c_fs = 0;
    for (int i = 0; i < 196; i++) begin
      step(1'b1, 1'b1);
      c_ls += int'(ls_a);
      c_fs += int'(fs_a);
      step(1'b1, 1'b0);
      c_ls += int'(ls_a);
      c_fs += int'(fs_a);
    end
    check_val("half_rate_line_starts", c_ls, 14);
    check_val("half_rate_frame_starts", c_fs, 2);

    // Look-ahead wraps across the frame boundary
    step(1'b0, 1'b1);
    for (int i = 0; i < 97; i++) step(1'b1, 1'b1);
    check_val("lead_x", int'(x_a), 12);
    check_val("lead_y", int'(y_a), 6);
    check_val("lead_fetch_x", int'(fx_a), 1);
    check_val("lead_fetch_y", int'(fy_a), 0);
    check_val("lead_fetch_de", int'(fde_a), 1);

    // Mid-frame reset at (5,3)
    step(1'b0, 1'b1);
    for (int i = 0; i < 48; i++) step(1'b1, 1'b1);
    check_val("pre_reset_x", int'(x_a), 5);
    check_val("pre_reset_y", int'(y_a), 3);
    step(1'b0, 1'b1);
    check_val("in_reset_hs", int'(hs_a), 1);
    check_val("in_reset_vs", int'(vs_a), 1);
    check_val("in_reset_de", int'(de_a), 0);
    step(1'b1, 1'b1);
    check_val("post_reset_x", int'(x_a), 0);
    check_val("post_reset_y", int'(y_a), 0);
    check_val("post_reset_fs", int'(fs_a), 1);
    check_val("post_reset_hs", int'(hs_a), 1);

    // Random enable with occasional reset
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)));
    end

    // Default 640x480 mode over the first line and across the line wrap
    step(1'b0, 1'b1);
    c_hs = 0; c_de = 0; c_ls = 0;
    for (int i = 0; i < 1700; i++) begin
      step(1'b1, 1'b1);
      if (i < 800) begin
        c_hs += int'(!hs_c);
        c_de += int'(de_c);
        c_ls += int'(ls_c);
      end
    end
    check_val("vga_hsync_ticks", c_hs, 96);
    check_val("vga_de_ticks", c_de, 640);
    check_val("vga_line_starts", c_ls, 1);
    check_val("vga_y_after_1700", int'(y_c), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
